// File: rtl/axilite_regif.sv
// AXI4-Lite slave that turns bus reads and writes into single-cycle strobes
// on the frame-sync controller's simple register port.
module axilite_regif #(
   parameter int C_DATA_WIDTH       = 32,
   parameter int C_REG_IDX_WIDTH    = 8,
   parameter int C_S_AXI_ADDR_WIDTH = 10
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
   input  logic                          s_axi_awvalid,
   output logic                          s_axi_awready,
   input  logic [C_DATA_WIDTH-1:0]       s_axi_wdata,
   input  logic [C_DATA_WIDTH/8-1:0]     s_axi_wstrb,
   input  logic                          s_axi_wvalid,
   output logic                          s_axi_wready,
   output logic [1:0]                    s_axi_bresp,
   output logic                          s_axi_bvalid,
   input  logic                          s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
   input  logic                          s_axi_arvalid,
   output logic                          s_axi_arready,
   output logic [C_DATA_WIDTH-1:0]       s_axi_rdata,
   output logic [1:0]                    s_axi_rresp,
   output logic                          s_axi_rvalid,
   input  logic                          s_axi_rready,
   output logic                          rd_en,
   output logic [C_REG_IDX_WIDTH-1:0]    rd_addr,
   input  logic [C_DATA_WIDTH-1:0]       rd_data,
   output logic                          wr_en,
   output logic [C_REG_IDX_WIDTH-1:0]    wr_addr,
   output logic [C_DATA_WIDTH-1:0]       wr_data
);

   localparam int STRB_WIDTH = C_DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      W_IDLE,
      W_EXEC,
      W_RESP
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE,
      R_EXEC,
      R_RESP
   } r_state_t;

   w_state_t                  w_state;
   w_state_t                  w_next;
   r_state_t                  r_state;
   r_state_t                  r_next;

   logic                      aw_held;
   logic                      w_held;
   logic                      aw_held_next;
   logic                      w_held_next;
   logic                      aw_hs;
   logic                      w_hs;
   logic                      ar_hs;
   logic                      strb_full;

   logic                      awready_q;
   logic                      wready_q;
   logic                      arready_q;
   logic [1:0]                bresp_q;
   logic [C_REG_IDX_WIDTH-1:0] wr_addr_q;
   logic [C_REG_IDX_WIDTH-1:0] rd_addr_q;
   logic [C_DATA_WIDTH-1:0]   wdata_q;
   logic [STRB_WIDTH-1:0]     wstrb_q;

   // Byte-offset bits and bits above the index are don't-care (addresses alias).
   logic                      unused_addr_bits;
   assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

   assign aw_hs     = awready_q & s_axi_awvalid;
   assign w_hs      = wready_q & s_axi_wvalid;
   assign ar_hs     = arready_q & s_axi_arvalid;
   assign strb_full = (wstrb_q == {STRB_WIDTH{1'b1}});

   always_comb begin
      w_next       = w_state;
      aw_held_next = aw_held | aw_hs;
      w_held_next  = w_held | w_hs;
      case (w_state)
         W_IDLE: begin
            if (aw_held_next && w_held_next) begin
               w_next = W_EXEC;
            end
         end
         W_EXEC: begin
            w_next = W_RESP;
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_next       = W_IDLE;
               aw_held_next = 1'b0;
               w_held_next  = 1'b0;
            end
         end
         default: begin
            w_next       = W_IDLE;
            aw_held_next = 1'b0;
            w_held_next  = 1'b0;
         end
      endcase
   end

   // Readies are registered from the next-state view so they never glitch.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_state   <= W_IDLE;
         aw_held   <= 1'b0;
         w_held    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bresp_q   <= 2'b00;
         wr_addr_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
      end else begin
         w_state   <= w_next;
         aw_held   <= aw_held_next;
         w_held    <= w_held_next;
         awready_q <= (w_next == W_IDLE) && !aw_held_next;
         wready_q  <= (w_next == W_IDLE) && !w_held_next;
         if (aw_hs) begin
            wr_addr_q <= s_axi_awaddr[C_REG_IDX_WIDTH+1:2];
         end
         if (w_hs) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
         end
         if (w_state == W_EXEC) begin
            bresp_q <= strb_full ? 2'b00 : 2'b10;
         end
      end
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE: begin
            if (ar_hs) begin
               r_next = R_EXEC;
            end
         end
         R_EXEC: begin
            r_next = R_RESP;
         end
         R_RESP: begin
            if (s_axi_rready) begin
               r_next = R_IDLE;
            end
         end
         default: begin
            r_next = R_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state   <= R_IDLE;
         arready_q <= 1'b0;
         rd_addr_q <= '0;
      end else begin
         r_state   <= r_next;
         arready_q <= (r_next == R_IDLE);
         if (ar_hs) begin
            rd_addr_q <= s_axi_araddr[C_REG_IDX_WIDTH+1:2];
         end
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = (w_state == W_RESP);
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = (r_state == R_RESP);
   assign s_axi_rresp   = 2'b00;
   // rd_data stays stable in R_RESP since no further rd_en is issued.
   assign s_axi_rdata   = rd_data;

   assign wr_en   = (w_state == W_EXEC) && strb_full;
   assign wr_addr = wr_addr_q;
   assign wr_data = wdata_q;
   assign rd_en   = (r_state == R_EXEC);
   assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_axilite_regif.sv
// Randomized self-checking bench for axilite_regif against a memory-level
// model of the register file and AXI timing rules.
`timescale 1ns/1ps
module tb_axilite_regif;

   logic        clk;
   logic        resetn;
   logic [9:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [9:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [31:0] rd_data;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int wr_cnt = 0;
   int wr_cyc = 0;
   logic [7:0]  wr_last_addr;
   logic [31:0] wr_last_data;
   int rd_cnt = 0;
   int rd_cyc = 0;
   logic [7:0]  rd_last_addr;

   int aw_cyc, w_cyc, ar_cyc;

   logic [31:0] regfile [256];
   logic [31:0] exp_mem [256];

   axilite_regif dut (
      .clk           (clk),
      .resetn        (resetn),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register file seen by the bridge: registered read data, write-after-read.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rd_data <= '0;
         for (int i = 0; i < 256; i++) regfile[i] <= '0;
      end else begin
         if (rd_en) rd_data <= regfile[rd_addr];
         if (wr_en) regfile[wr_addr] <= wr_data;
      end
   end

   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt++;
         wr_cyc = cyc;
         wr_last_addr = wr_addr;
         wr_last_data = wr_data;
      end
      if (rd_en) begin
         rd_cnt++;
         rd_cyc = cyc;
         rd_last_addr = rd_addr;
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic int idxOf(input logic [9:0] addr);
      return (int'(addr) / 4) % 256;
   endfunction

   task automatic sendAw(input logic [9:0] addr, input int dly);
      bit ok = 0;
      repeat (dly) @(negedge clk);
      s_axi_awaddr  = addr;
      s_axi_awvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (s_axi_awready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(negedge clk);
         aw_cyc = cyc;
      end else checkOutput("aw_timeout", 0, 1);
      s_axi_awvalid = 1'b0;
   endtask

   task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input int dly);
      bit ok = 0;
      repeat (dly) @(negedge clk);
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      s_axi_wvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (s_axi_wready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(negedge clk);
         w_cyc = cyc;
      end else checkOutput("w_timeout", 0, 1);
      s_axi_wvalid = 1'b0;
   endtask

   task automatic sendAr(input logic [9:0] addr);
      bit ok = 0;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (s_axi_arready) begin ok = 1; break; end
         @(negedge clk);
      end
      if (ok) begin
         @(negedge clk);
         ar_cyc = cyc;
      end else checkOutput("ar_timeout", 0, 1);
      s_axi_arvalid = 1'b0;
   endtask

   task automatic waitResp(input int b_hold, input int hs_cyc, input logic [1:0] exp_resp);
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (s_axi_bvalid) begin ok = 1; break; end
         checkOutput("busy_awready", s_axi_awready, 0);
         @(negedge clk);
      end
      if (!ok) begin
         checkOutput("b_timeout", 0, 1);
         return;
      end
      checkOutput("bvalid_latency", cyc, hs_cyc + 1);
      repeat (b_hold) begin
         checkOutput("bvalid_held", s_axi_bvalid, 1);
         checkOutput("wready_held_low", s_axi_wready, 0);
         @(negedge clk);
      end
      checkOutput("bresp", s_axi_bresp, exp_resp);
      s_axi_bready = 1'b1;
      @(negedge clk);
      s_axi_bready = 1'b0;
      checkOutput("bvalid_cleared", s_axi_bvalid, 0);
   endtask

   task automatic axiWrite(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_hold);
      int wr0 = wr_cnt;
      int idx = idxOf(addr);
      int hs;
      fork
         sendAw(addr, aw_dly);
         sendW(data, strb, w_dly);
      join
      hs = (aw_cyc > w_cyc) ? aw_cyc : w_cyc;
      waitResp(b_hold, hs, (strb == 4'hF) ? 2'b00 : 2'b10);
      if (strb == 4'hF) begin
         checkOutput("wr_en_count", wr_cnt - wr0, 1);
         checkOutput("wr_en_cycle", wr_cyc, hs);
         checkOutput("wr_addr", wr_last_addr, idx);
         checkOutput("wr_data", wr_last_data, data);
         exp_mem[idx] = data;
      end else begin
         checkOutput("partial_no_wr_en", wr_cnt - wr0, 0);
      end
   endtask

   task automatic axiRead(input logic [9:0] addr, input int r_hold);
      int rd0 = rd_cnt;
      int idx = idxOf(addr);
      logic [31:0] exp = exp_mem[idx];
      bit ok = 0;
      sendAr(addr);
      for (int i = 0; i < 50; i++) begin
         if (s_axi_rvalid) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checkOutput("r_timeout", 0, 1);
         return;
      end
      checkOutput("rvalid_latency", cyc, ar_cyc + 1);
      checkOutput("rd_en_count", rd_cnt - rd0, 1);
      checkOutput("rd_en_cycle", rd_cyc, ar_cyc);
      checkOutput("rd_addr", rd_last_addr, idx);
      checkOutput("rdata", s_axi_rdata, exp);
      checkOutput("rresp", s_axi_rresp, 0);
      repeat (r_hold) begin
         @(negedge clk);
         checkOutput("rvalid_held", s_axi_rvalid, 1);
         checkOutput("rdata_stable", s_axi_rdata, exp);
         checkOutput("arready_held_low", s_axi_arready, 0);
      end
      s_axi_rready = 1'b1;
      @(negedge clk);
      s_axi_rready = 1'b0;
      checkOutput("rvalid_cleared", s_axi_rvalid, 0);
   endtask

   task automatic applyStimulus();
      logic [9:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      addr = {3'd0, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 3) == 0) addr = 10'($urandom);
      data = $urandom;
      strb = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if ($urandom_range(0, 1) == 1)
         axiWrite(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
         axiRead(addr, $urandom_range(0, 2));
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_readys"}, {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
      checkOutput({tag, "_valids"}, {s_axi_bvalid, s_axi_rvalid}, 2'b00);
      checkOutput({tag, "_strobes"}, {rd_en, wr_en}, 2'b00);
      checkOutput({tag, "_bresp"}, s_axi_bresp, 0);
      checkOutput({tag, "_idx"}, {rd_addr, wr_addr}, 0);
      checkOutput({tag, "_wr_data"}, wr_data, 0);
   endtask

   initial begin
      int wr0;
      resetn = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
      s_axi_wdata = '0;  s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
      s_axi_bready = 1'b0;
      s_axi_araddr = '0; s_axi_arvalid = 1'b0;
      s_axi_rready = 1'b0;
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;

      repeat (3) @(negedge clk);
      checkResetOutputs("reset");
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_release", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

      $display("[TB] basic write to 0x004");
      axiWrite(10'h004, 32'h0000_0003, 4'hF, 0, 0, 0);

      $display("[TB] W three cycles before AW to 0x3FC");
      axiWrite(10'h3FC, 32'hA5A5_0FF0, 4'hF, 3, 0, 0);

      $display("[TB] AW first, awready must stay low");
      wr0 = wr_cnt;
      fork
         sendAw(10'h010, 0);
         sendW(32'h1234_5678, 4'hF, 3);
         begin
            @(negedge clk);
            @(negedge clk);
            checkOutput("awready_after_aw", s_axi_awready, 0);
         end
      join
      waitResp(1, w_cyc, 2'b00);
      checkOutput("aw_first_wr_count", wr_cnt - wr0, 1);
      exp_mem[4] = 32'h1234_5678;

      $display("[TB] partial strobe write");
      axiWrite(10'h00C, 32'hFFFF_FFFF, 4'h3, 0, 0, 0);

      $display("[TB] read 0x008 with back-pressure");
      axiWrite(10'h008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
      axiRead(10'h008, 5);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 60; n++) applyStimulus();

      $display("[TB] concurrent read/write to index 1, then reset in W_RESP");
      wr0 = wr_cnt;
      fork
         axiRead(10'h004, 0);
         sendAw(10'h005, 0);
         sendW(32'hCAFE_F00D, 4'hF, 0);
      join
      checkOutput("same_cycle_strobes", rd_cyc, wr_cyc);
      checkOutput("concurrent_wr_count", wr_cnt - wr0, 1);
      for (int i = 0; i < 10 && !s_axi_bvalid; i++) @(negedge clk);
      checkOutput("bvalid_before_reset", s_axi_bvalid, 1);
      @(posedge clk);
      #2 resetn = 1'b0;
      #1 checkOutput("bvalid_drops_on_reset", s_axi_bvalid, 0);
      checkResetOutputs("midreset");
      for (int i = 0; i < 256; i++) exp_mem[i] = '0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_rerelease", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
      axiRead(10'h004, 0);
      axiWrite(10'h004, 32'h0BAD_CAFE, 4'hF, 1, 0, 0);
      axiRead(10'h004, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
